// File: rtl/ex_stage.sv
// ex_stage: execute stage with single-cycle ALU and 32-step restoring divider
module ex_stage #(
   parameter int WORD_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        ex_alusel,
   input  logic [4:0]        ex_aluop,
   input  logic [WORD_W-1:0] ex_srcl,
   input  logic [WORD_W-1:0] ex_srcr,
   input  logic [15:0]       ex_offset,
   input  logic [2:0]        ex_memop,
   input  logic [REG_W-1:0]  ex_dest,
   input  logic              ex_writeEnable,
   output logic              stall_req,
   output logic [WORD_W-1:0] mem_result,
   output logic [WORD_W-1:0] mem_hi,
   output logic              mem_hilo_we,
   output logic [WORD_W-1:0] mem_addr,
   output logic [2:0]        mem_memop,
   output logic [REG_W-1:0]  mem_dest,
   output logic              mem_writeEnable
);
   localparam int OW = WORD_W - 16;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nx;
   logic [4:0] cnt;
   logic [WORD_W-1:0] q, rem, dvs, dvd, alu_res, abs_l, abs_r, q_fix, r_fix, ext_off;
   logic [WORD_W:0] diff;
   logic neg_q, neg_r, dz, is_div, sgn_op, l_we;
   logic [2:0] l_memop;
   logic [REG_W-1:0] l_dest;
   assign is_div  = ex_alusel == 3'd4;
   assign sgn_op  = ex_aluop == 5'd0;
   assign abs_l   = (sgn_op && ex_srcl[WORD_W-1]) ? -ex_srcl : ex_srcl;
   assign abs_r   = (sgn_op && ex_srcr[WORD_W-1]) ? -ex_srcr : ex_srcr;
   assign ext_off = {{OW{ex_offset[15]}}, ex_offset};
   assign diff    = {rem, q[WORD_W-1]} - {1'b0, dvs};
   // divide-by-zero bypasses sign correction and returns the raw dividend
   assign q_fix   = dz ? '1 : neg_q ? -q : q;
   assign r_fix   = dz ? dvd : neg_r ? -rem : rem;
   assign stall_req = !rst && (state == RUN || (state == IDLE && is_div));
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = is_div ? RUN : IDLE;
         RUN:     state_nx = (cnt == 5'd31) ? DONE : RUN;
         default: state_nx = IDLE;
      endcase
   end
   always_comb begin
      alu_res = '0;
      case (ex_alusel)
         3'd1: case (ex_aluop)
            5'd0: alu_res = ex_srcl & ex_srcr;
            5'd1: alu_res = ex_srcl | ex_srcr;
            5'd2: alu_res = ex_srcl ^ ex_srcr;
            5'd3: alu_res = ~(ex_srcl | ex_srcr);
            5'd4: alu_res = {ex_offset, {OW{1'b0}}};
            default: ;
         endcase
         3'd2: case (ex_aluop)
            5'd0: alu_res = ex_srcl << ex_srcr[4:0];
            5'd1: alu_res = ex_srcl >> ex_srcr[4:0];
            5'd2: alu_res = $signed(ex_srcl) >>> ex_srcr[4:0];
            default: ;
         endcase
         3'd3: case (ex_aluop)
            5'd0: alu_res = ex_srcl + ex_srcr;
            5'd1: alu_res = ex_srcl - ex_srcr;
            5'd2: alu_res = {{(WORD_W-1){1'b0}}, $signed(ex_srcl) < $signed(ex_srcr)};
            5'd3: alu_res = {{(WORD_W-1){1'b0}}, ex_srcl < ex_srcr};
            default: ;
         endcase
         3'd4: ;
         default: alu_res = ex_srcr;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         mem_result      <= '0;
         mem_hi          <= '0;
         mem_hilo_we     <= 1'b0;
         mem_addr        <= '0;
         mem_memop       <= '0;
         mem_dest        <= '0;
         mem_writeEnable <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               mem_hilo_we <= 1'b0;
               if (is_div) begin
                  q               <= abs_l;
                  rem             <= '0;
                  dvs             <= abs_r;
                  dvd             <= ex_srcl;
                  dz              <= ex_srcr == '0;
                  neg_q           <= sgn_op && (ex_srcl[WORD_W-1] ^ ex_srcr[WORD_W-1]);
                  neg_r           <= sgn_op && ex_srcl[WORD_W-1];
                  l_memop         <= ex_memop;
                  l_dest          <= ex_dest;
                  l_we            <= ex_writeEnable;
                  cnt             <= '0;
                  mem_memop       <= '0;
                  mem_writeEnable <= 1'b0;
               end else begin
                  mem_result      <= alu_res;
                  mem_addr        <= ex_srcl + ext_off;
                  mem_memop       <= ex_memop;
                  mem_dest        <= ex_dest;
                  mem_writeEnable <= ex_writeEnable;
               end
            end
            RUN: begin
               rem             <= diff[WORD_W] ? {rem[WORD_W-2:0], q[WORD_W-1]} : diff[WORD_W-1:0];
               q               <= {q[WORD_W-2:0], !diff[WORD_W]};
               cnt             <= cnt + 5'd1;
               mem_memop       <= '0;
               mem_writeEnable <= 1'b0;
               mem_hilo_we     <= 1'b0;
            end
            DONE: begin
               mem_result      <= q_fix;
               mem_hi          <= r_fix;
               mem_hilo_we     <= 1'b1;
               mem_memop       <= l_memop;
               mem_dest        <= l_dest;
               mem_writeEnable <= l_we;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against an arithmetic reference model
module tb_ex_stage;
   logic clk = 1'b0;
   logic rst;
   logic [2:0] ex_alusel, ex_memop, mem_memop;
   logic [4:0] ex_aluop, ex_dest, mem_dest;
   logic [31:0] ex_srcl, ex_srcr, mem_result, mem_hi, mem_addr;
   logic [15:0] ex_offset;
   logic ex_writeEnable, stall_req, mem_hilo_we, mem_writeEnable;
   int checks = 0, errors = 0;
   logic [31:0] exp_hi;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk(clk), .rst(rst), .ex_alusel(ex_alusel), .ex_aluop(ex_aluop),
      .ex_srcl(ex_srcl), .ex_srcr(ex_srcr), .ex_offset(ex_offset), .ex_memop(ex_memop),
      .ex_dest(ex_dest), .ex_writeEnable(ex_writeEnable), .stall_req(stall_req),
      .mem_result(mem_result), .mem_hi(mem_hi), .mem_hilo_we(mem_hilo_we),
      .mem_addr(mem_addr), .mem_memop(mem_memop), .mem_dest(mem_dest),
      .mem_writeEnable(mem_writeEnable)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [4:0] op,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [15:0] off);
      int sh;
      logic [31:0] ones;
      sh = int'(b[4:0]);
      ones = '1;
      case (sel)
         3'd1: return op == 0 ? (a & b) : op == 1 ? (a | b) : op == 2 ? (a ^ b) :
                      op == 3 ? ~(a | b) : op == 4 ? {off, 16'h0} : 32'h0;
         3'd2: return op == 0 ? a << sh : op == 1 ? a >> sh :
                      op == 2 ? ((a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0)) : 32'h0;
         3'd3: begin
            if (op == 0) return a + b;
            if (op == 1) return a - b;
            if (op == 2) return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            if (op == 3) return (a < b) ? 32'd1 : 32'd0;
            return 32'h0;
         end
         default: return b;
      endcase
   endfunction

   task automatic ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r);
      if (b == 0) begin
         q = '1;
         r = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         q = 32'h8000_0000;
         r = 0;
      end else if (sgn) begin
         q = 32'(int'(a) / int'(b));
         r = 32'(int'(a) % int'(b));
      end else begin
         q = a / b;
         r = a % b;
      end
   endtask

   task automatic drive(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [15:0] off, input logic [2:0] mo,
                        input logic [4:0] d, input logic we);
      ex_alusel = sel; ex_aluop = op; ex_srcl = a; ex_srcr = b;
      ex_offset = off; ex_memop = mo; ex_dest = d; ex_writeEnable = we;
   endtask

   task automatic do_single(input logic [2:0] sel, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [15:0] off, input logic [2:0] mo,
                            input logic [4:0] d, input logic we);
      logic [31:0] er, ea;
      er = ref_alu(sel, op, a, b, off);
      ea = a + 32'(int'($signed(off)));
      drive(sel, op, a, b, off, mo, d, we);
      #1 check("single_stall", 32'(stall_req), 0);
      @(posedge clk); #1;
      check($sformatf("result sel%0d op%0d", sel, op), mem_result, er);
      check("addr", mem_addr, ea);
      check("memop", 32'(mem_memop), 32'(mo));
      check("dest", 32'(mem_dest), 32'(d));
      check("we", 32'(mem_writeEnable), 32'(we));
      check("hilo_we_single", 32'(mem_hilo_we), 0);
      check("hi_hold", mem_hi, exp_hi);
   endtask

   task automatic do_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      logic [2:0] mo;
      logic [4:0] d;
      logic we;
      int n;
      mo = 3'($urandom); d = 5'($urandom); we = 1'($urandom);
      ref_div(op == 0, a, b, eq, er);
      drive(3'd4, op, a, b, 16'($urandom), mo, d, we);
      n = 0;
      #1;
      while (stall_req && n < 100) begin
         n++;
         @(posedge clk); #1;
         check("div_bubble_we", 32'(mem_writeEnable), 0);
         check("div_bubble_memop", 32'(mem_memop), 0);
         check("div_bubble_hilo", 32'(mem_hilo_we), 0);
      end
      check("div_stall_len", n, 33);
      @(posedge clk); #1;
      check($sformatf("div_q %h/%h op%0d", a, b, op), mem_result, eq);
      check($sformatf("div_r %h/%h op%0d", a, b, op), mem_hi, er);
      check("div_hilo_we", 32'(mem_hilo_we), 1);
      check("div_dest", 32'(mem_dest), 32'(d));
      check("div_memop", 32'(mem_memop), 32'(mo));
      check("div_we", 32'(mem_writeEnable), 32'(we));
      exp_hi = er;
   endtask

   initial begin
      rst = 1'b1;
      exp_hi = 0;
      drive(3'd4, 5'd0, 32'd9, 32'd2, 16'h0, 3'd1, 5'd1, 1'b1);
      #1 check("reset_stall", 32'(stall_req), 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_result", mem_result, 0);
      check("rst_hi", mem_hi, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_memop", 32'(mem_memop), 0);
      check("rst_dest", 32'(mem_dest), 0);
      check("rst_we", 32'(mem_writeEnable), 0);
      check("rst_hilo", 32'(mem_hilo_we), 0);
      rst = 1'b0;
      do_single(3'd1, 5'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 16'h0, 3'd1, 5'd3, 1'b1);
      do_single(3'd1, 5'd4, 32'h0, 32'h0, 16'h1234, 3'd1, 5'd4, 1'b1);
      do_single(3'd3, 5'd2, 32'hFFFF_FFFF, 32'd1, 16'h0, 3'd1, 5'd5, 1'b1);
      do_single(3'd3, 5'd3, 32'hFFFF_FFFF, 32'd1, 16'h0, 3'd1, 5'd5, 1'b1);
      do_single(3'd0, 5'd0, 32'h100, 32'hDEAD_BEEF, 16'hFFFC, 3'd3, 5'd0, 1'b0);
      check("addr_directed", mem_addr, 32'hFC);
      for (int i = 0; i < 200; i++) begin
         logic [2:0] s;
         s = 3'($urandom_range(0, 6));
         if (s >= 3'd4) s++;
         do_single(s, 5'($urandom_range(0, 7)), $urandom, $urandom, 16'($urandom),
                   3'($urandom), 5'($urandom), 1'($urandom));
      end
      do_div(5'd0, 32'hFFFF_FFF9, 32'd2);
      do_div(5'd1, 32'h55, 32'd0);
      do_div(5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
      do_div(5'd1, 32'd100, 32'd7);
      do_div(5'd0, 32'h8000_0000, 32'd0);
      for (int i = 0; i < 20; i++) begin
         logic [31:0] dv;
         dv = (i % 5 == 0) ? 32'h0 : (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
         if (i % 3 == 0) dv = -dv;
         do_div(5'($urandom_range(0, 2)), $urandom, dv);
         do_single(3'd3, 5'd0, $urandom, $urandom, 16'($urandom), 3'd1, 5'($urandom), 1'b1);
      end
      drive(3'd4, 5'd1, 32'd1000, 32'd3, 16'h0, 3'd1, 5'd7, 1'b1);
      #1 check("abort_stall_start", 32'(stall_req), 1);
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         check("abort_hilo_run", 32'(mem_hilo_we), 0);
      end
      rst = 1'b1;
      #1 check("abort_stall_rst", 32'(stall_req), 0);
      @(posedge clk); #1;
      check("abort_result", mem_result, 0);
      check("abort_hi", mem_hi, 0);
      check("abort_addr", mem_addr, 0);
      check("abort_memop", 32'(mem_memop), 0);
      check("abort_dest", 32'(mem_dest), 0);
      check("abort_we", 32'(mem_writeEnable), 0);
      check("abort_hilo", 32'(mem_hilo_we), 0);
      rst = 1'b0;
      exp_hi = 0;
      do_single(3'd3, 5'd0, 32'd40, 32'd2, 16'h0, 3'd1, 5'd9, 1'b1);
      do_div(5'd1, 32'd1000, 32'd3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
